// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 access encodings and FSM states.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_if.sv
// Memory request/response channel between the LSU (master) and the memory (slave).
interface lsu_mem_if #(
    parameter int DataWidth = 32
);
    // Request: mem_req_o and all request fields stay stable until mem_gnt_i is
    // sampled high; the transfer happens on that edge. Response: mem_rvalid_i is
    // a single-cycle strobe qualifying mem_rdata_i, with no back-pressure.
    logic                 mem_req_o;
    logic                 mem_gnt_i;
    logic                 mem_we_o;
    logic [3:0]           mem_be_o;
    logic [DataWidth-1:0] mem_addr_o;
    logic [DataWidth-1:0] mem_wdata_o;
    logic                 mem_rvalid_i;
    logic [DataWidth-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: byte enables, store replication, load
// extraction/extension and the illegal/misaligned check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        err
);

    logic [31:0] shifted;
    logic        illegal;
    logic        misaligned;

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = wdata;
        load_data  = 32'h0;
        illegal    = 1'b0;
        misaligned = 1'b0;
        shifted    = rdata >> {offset, 3'b000};

        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << offset;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = offset[0];
            end
            2'b10: begin
                be         = 4'b1111;
                misaligned = (offset != 2'b00);
            end
            default: illegal = 1'b1;
        endcase

        // Stores have no unsigned variants; loads additionally reject 110.
        if (we) begin
            illegal = illegal | funct3[2];
        end else begin
            illegal = illegal | (funct3 == 3'b110);
        end

        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = shifted;
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = 32'h0;
        endcase

        err = illegal | misaligned;
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one core request at a time, turned into a single word-aligned
// memory transaction with byte enables, or rejected early on a bad access.
module lsu
    import lsu_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [2:0]           funct3_i,
    input  logic [DataWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 stall_o,
    output lsu_state_e           state_o,
    lsu_mem_if.master            mem
);

    lsu_state_e           state;
    logic                 we_q;
    logic [2:0]           f3_q;
    logic [DataWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;

    logic                 idle;
    logic                 in_req;
    logic                 sel_we;
    logic [2:0]           sel_f3;
    logic [1:0]           sel_off;
    logic [DataWidth-1:0] sel_wdata;
    logic [3:0]           al_be;
    logic [DataWidth-1:0] al_wdata;
    logic [DataWidth-1:0] al_load;
    logic                 al_err;

    assign idle   = (state == IDLE);
    assign in_req = (state == REQ);

    // In IDLE the aligner checks the incoming op; afterwards it works on the latched op.
    assign sel_we    = idle ? we_i           : we_q;
    assign sel_f3    = idle ? funct3_i       : f3_q;
    assign sel_off   = idle ? addr_i[1:0]    : addr_q[1:0];
    assign sel_wdata = idle ? wdata_i        : wdata_q;

    lsu_align u_align (
        .we        (sel_we),
        .funct3    (sel_f3),
        .offset    (sel_off),
        .wdata     (sel_wdata),
        .rdata     (mem.mem_rdata_i),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .load_data (al_load),
        .err       (al_err)
    );

    assign mem.mem_req_o   = in_req;
    assign mem.mem_we_o    = in_req & we_q;
    assign mem.mem_be_o    = in_req ? al_be : 4'b0000;
    assign mem.mem_addr_o  = in_req ? {addr_q[DataWidth-1:2], 2'b00} : '0;
    assign mem.mem_wdata_o = (in_req && we_q) ? al_wdata : '0;

    assign stall_o = req_i & ~done_o;
    assign state_o = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_o <= '0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        if (al_err) begin
                            state  <= RESP;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else begin
                            state   <= REQ;
                            we_q    <= we_i;
                            f3_q    <= funct3_i;
                            addr_q  <= addr_i;
                            wdata_q <= wdata_i;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_gnt_i) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid_i) begin
                        state  <= RESP;
                        done_o <= 1'b1;
                        if (!we_q) begin
                            rdata_o <= al_load;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter DataWidth, default 32, SHALL set the width of the data and address paths; only 32 is supported.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 req_i  input  1  SHALL request a memory op from the core, held high until done_o.
REQ-005 we_i  input  1  SHALL select store (1) or load (0).
REQ-006 funct3_i  input  3  SHALL select the access: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-007 addr_i  input  32  SHALL be the effective byte address, taken from the ALU result.
REQ-008 wdata_i  input  32  SHALL be the store data (rs2).
REQ-009 rdata_o  output  32  SHALL be the extended load data, valid when done_o=1.
REQ-010 done_o  output  1  SHALL pulse one cycle when the op completes.
REQ-011 err_o  output  1  SHALL pulse with done_o on a misaligned access or an illegal funct3.
REQ-012 stall_o  output  1  SHALL equal req_i & ~done_o, combinationally.
REQ-013 mem_req_o/mem_gnt_i/mem_we_o/mem_be_o[3:0]/mem_addr_o[31:0]/mem_wdata_o[31:0] SHALL form the memory request channel.
REQ-014 mem_rvalid_i/mem_rdata_i[31:0] SHALL form the memory response channel.

Function
REQ-015 The FSM SHALL have four states: IDLE, REQ, WAIT and RESP.
REQ-016 In IDLE, req_i=1 with a legal, aligned op SHALL latch we/funct3/addr/wdata and go to REQ.
REQ-017 In IDLE, req_i=1 with an illegal or misaligned op SHALL go to RESP with the error flag set, issuing no bus transaction.
- Misaligned means: H with addr[0]=1; W with addr[1:0]!=0.
- Illegal means: load funct3 011/110/111; store funct3 >=011.
REQ-018 In REQ, mem_req_o SHALL be 1 and held stable until mem_gnt_i=1, and the FSM SHALL then go to WAIT.
REQ-019 In WAIT, mem_rvalid_i=1 SHALL go to RESP; for loads it SHALL also register the extracted data.
REQ-020 In RESP, done_o SHALL be 1 and the FSM SHALL go to IDLE; err_o SHALL be 1 only on the error path.
REQ-021 mem_rvalid_i outside WAIT SHALL be ignored.
REQ-022 mem_addr_o SHALL be {addr[31:2],2'b00}, mem_we_o SHALL be the latched we, and the request fields SHALL be driven only in REQ.
REQ-023 mem_be_o SHALL be 4'b0001<<addr[1:0] for B, 4'b0011<<addr[1:0] for H, and 4'b1111 for W.
REQ-024 mem_wdata_o SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-025 Load data SHALL be mem_rdata_i>>(8*addr[1:0]), truncated to 8 or 16 bits, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-026 rdata_o SHALL hold its last load value across stores and errors.
REQ-027 Minimum latency SHALL be 3 cycles from the first edge sampling req_i in IDLE to done_o (zero-wait gnt and rvalid).
REQ-028 A new request SHALL be accepted no earlier than the cycle after done_o.

Reset
REQ-029 On rst_ni=0 the FSM SHALL enter IDLE.
REQ-030 On reset, rdata_o, latched fields, mem_req_o, mem_we_o, mem_be_o, done_o and err_o SHALL all be 0.
REQ-031 Reset mid-transaction SHALL drop mem_req_o immediately, and a late mem_rvalid_i SHALL be discarded.

Structure
REQ-032 The shared core package SHALL hold the funct3 load/store enum and the lsu_state_e typedef (IDLE, REQ, WAIT, RESP).
REQ-033 Alignment logic SHALL live in a combinational sub-module lsu_align: be, write replication, load extraction/extension and the error check.

Verification
REQ-034 LW addr 0x100, gnt and rvalid immediate, rdata 0xDEADBEEF -> done_o at cycle 3, rdata_o=0xDEADBEEF, be=1111, err_o=0.
REQ-035 LB addr 0x103, rdata 0x80FF_0000 -> rdata_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SH addr 0x202, wdata 0x1234ABCD -> be=1100, mem_wdata_o=0xABCDABCD, mem_addr_o=0x200, rdata_o unchanged.
REQ-037 LW addr 0x101 -> no mem_req_o, done_o=err_o=1 one cycle after the request; funct3 011 load -> same.
REQ-038 gnt withheld 4 cycles -> mem_req_o and all fields stable, stall_o=1 throughout, done_o 4 cycles later than minimum.
REQ-039 rst_ni low during WAIT, rvalid pulses after release -> FSM IDLE, no done_o, rdata_o=0.
